// File: rtl/dds_ddc_center_dbg_pkg.sv
// rtl/dds_ddc_center_dbg_pkg.sv - shared types, defaults and helpers for the deadlock watchdog
package dds_ddc_center_dbg_pkg;

    localparam int N_AXIS_DEF = 4;
    localparam int N_INST_DEF = 1;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WATCH,
        ST_SUSPECT,
        ST_DEADLOCK
    } wd_state_t;

    // Index of the lowest set bit; 0 when nothing is set (inst-only block).
    function automatic int lowest_set_bit(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dds_ddc_center_block_sampler.sv
// rtl/dds_ddc_center_block_sampler.sv - qualifies raw block sources and registers them with the axis sample
module dds_ddc_center_block_sampler
    import dds_ddc_center_dbg_pkg::*;
#(
    parameter int N_AXIS = N_AXIS_DEF,
    parameter int N_INST = N_INST_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              blk_q,
    output logic [N_AXIS-1:0] axis_q
);

    // An idle sub-instance reporting block is not a stall.
    logic raw;
    assign raw = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs));

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_q  <= 1'b0;
            axis_q <= '0;
        end else begin
            blk_q  <= raw;
            axis_q <= axis_block_sigs;
        end
    end

endmodule

// File: rtl/dds_ddc_center_deadlock_watchdog.sv
// rtl/dds_ddc_center_deadlock_watchdog.sv - turns qualified block samples into a sticky deadlock flag and irq
module dds_ddc_center_deadlock_watchdog
    import dds_ddc_center_dbg_pkg::*;
#(
    parameter int N_AXIS = N_AXIS_DEF,
    parameter int N_INST = N_INST_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int IDX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              enable,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              clear,
    output logic              block_now,
    output logic              deadlock,
    output logic              irq,
    output logic [N_AXIS-1:0] blocked_mask,
    output logic [IDX_W-1:0]  first_idx,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] ONES = '1;

    logic              blk_q;
    logic [N_AXIS-1:0] axis_q;
    wd_state_t         state, state_nxt;
    logic [CNT_W-1:0]  run_cnt, run_nxt, run_inc;
    logic [CNT_W-1:0]  thr_q, thr_nxt, eff_thr;
    logic [N_AXIS-1:0] mask_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CNT_W-1:0]  stall_nxt;
    logic              irq_nxt;

    dds_ddc_center_block_sampler #(
        .N_AXIS (N_AXIS),
        .N_INST (N_INST)
    ) u_sampler (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .blk_q           (blk_q),
        .axis_q          (axis_q)
    );

    assign block_now = blk_q;
    assign deadlock  = (state == ST_DEADLOCK);
    assign eff_thr   = (threshold == '0) ? CNT_W'(1) : threshold;
    assign run_inc   = (run_cnt == ONES) ? run_cnt : run_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        thr_nxt   = thr_q;
        mask_nxt  = blocked_mask;
        idx_nxt   = first_idx;
        stall_nxt = stall_cycles;

        if (blk_q && state != ST_IDLE && stall_cycles != ONES)
            stall_nxt = stall_cycles + CNT_W'(1);

        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WATCH;
            end
            ST_WATCH: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    run_nxt   = '0;
                end else if (blk_q) begin
                    // Episode start: latch threshold so mid-episode edits wait for the next one.
                    mask_nxt  = axis_q;
                    idx_nxt   = IDX_W'(lowest_set_bit(32'(axis_q)));
                    thr_nxt   = eff_thr;
                    run_nxt   = CNT_W'(1);
                    state_nxt = (eff_thr == CNT_W'(1)) ? ST_DEADLOCK : ST_SUSPECT;
                end
            end
            ST_SUSPECT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    run_nxt   = '0;
                end else if (!blk_q) begin
                    state_nxt = ST_WATCH;
                    run_nxt   = '0;
                end else begin
                    run_nxt  = run_inc;
                    mask_nxt = blocked_mask | axis_q;
                    if (run_inc >= thr_q) state_nxt = ST_DEADLOCK;
                end
            end
            default: ;
        endcase

        if (clear) begin
            run_nxt   = '0;
            stall_nxt = '0;
            mask_nxt  = '0;
            idx_nxt   = '0;
            state_nxt = enable ? ST_WATCH : ST_IDLE;
        end

        irq_nxt = (state_nxt == ST_DEADLOCK) && (state != ST_DEADLOCK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            run_cnt      <= '0;
            thr_q        <= '0;
            blocked_mask <= '0;
            first_idx    <= '0;
            stall_cycles <= '0;
            irq          <= 1'b0;
        end else begin
            state        <= state_nxt;
            run_cnt      <= run_nxt;
            thr_q        <= thr_nxt;
            blocked_mask <= mask_nxt;
            first_idx    <= idx_nxt;
            stall_cycles <= stall_nxt;
            irq          <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_dds_ddc_center_deadlock_watchdog.sv
// tb/tb_dds_ddc_center_deadlock_watchdog.sv - scoreboard bench for the deadlock watchdog
module tb_dds_ddc_center_deadlock_watchdog;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  axis_block_sigs;
    logic [0:0]  inst_idle_sigs;
    logic [0:0]  inst_block_sigs;
    logic        enable;
    logic [15:0] threshold;
    logic [3:0]  threshold_b;
    logic        clear;

    logic        block_now, deadlock, irq;
    logic [3:0]  blocked_mask;
    logic [1:0]  first_idx;
    logic [15:0] stall_cycles;

    logic        block_now_b, deadlock_b, irq_b;
    logic [3:0]  blocked_mask_b;
    logic [1:0]  first_idx_b;
    logic [3:0]  stall_cycles_b;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   total = 0;
    int   bad = 0;

    localparam int S_BLK = 0, S_DL = 1, S_IRQ = 2, S_MASK = 3, S_IDX = 4, S_STALL = 5,
                   S_DL_B = 6, S_STALL_B = 7;

    dds_ddc_center_deadlock_watchdog #(.N_AXIS(4), .N_INST(1), .CNT_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .enable          (enable),
        .threshold       (threshold),
        .clear           (clear),
        .block_now       (block_now),
        .deadlock        (deadlock),
        .irq             (irq),
        .blocked_mask    (blocked_mask),
        .first_idx       (first_idx),
        .stall_cycles    (stall_cycles)
    );

    dds_ddc_center_deadlock_watchdog #(.N_AXIS(4), .N_INST(1), .CNT_W(4)) dut_b (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .enable          (enable),
        .threshold       (threshold_b),
        .clear           (clear),
        .block_now       (block_now_b),
        .deadlock        (deadlock_b),
        .irq             (irq_b),
        .blocked_mask    (blocked_mask_b),
        .first_idx       (first_idx_b),
        .stall_cycles    (stall_cycles_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int probe(input int sel);
        case (sel)
            S_BLK:     return int'(block_now);
            S_DL:      return int'(deadlock);
            S_IRQ:     return int'(irq);
            S_MASK:    return int'(blocked_mask);
            S_IDX:     return int'(first_idx);
            S_STALL:   return int'(stall_cycles);
            S_DL_B:    return int'(deadlock_b);
            S_STALL_B: return int'(stall_cycles_b);
            default:   return -1;
        endcase
    endfunction

    // Monitor: every expectation due this cycle is compared, stale ones are failures.
    always @(negedge clock) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                total++;
                if (q[i].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: check for cycle %0d was never evaluated", q[i].name, q[i].cyc - base);
                end else if (probe(q[i].sel) != q[i].val) begin
                    bad++;
                    $display("FAIL %s @c%0d: got %0d expected %0d", q[i].name, q[i].cyc - base,
                             probe(q[i].sel), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int n, input int sel, input int val, input string name);
        exp_t e;
        e.cyc  = base + n;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc - base < n) step();
    endtask

    task automatic start();
        reset           = 1'b1;
        enable          = 1'b0;
        clear           = 1'b0;
        axis_block_sigs = '0;
        inst_block_sigs = '0;
        inst_idle_sigs  = '0;
        threshold       = '0;
        step();
        step();
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(posedge clock);
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        threshold_b = 4'd15;

        // Held single-stream block, threshold 4
        start();
        enable = 1'b1; threshold = 16'd4; axis_block_sigs = 4'b0100;
        expect_at(0, S_BLK, 0, "rst_block_now");
        expect_at(0, S_DL, 0, "rst_deadlock");
        expect_at(0, S_IRQ, 0, "rst_irq");
        expect_at(0, S_MASK, 0, "rst_mask");
        expect_at(0, S_STALL, 0, "rst_stall");
        expect_at(1, S_BLK, 1, "t1_block_now");
        expect_at(4, S_DL, 0, "t1_no_dl_early");
        expect_at(5, S_DL, 1, "t1_deadlock");
        expect_at(5, S_IRQ, 1, "t1_irq");
        expect_at(5, S_IDX, 2, "t1_first_idx");
        expect_at(5, S_MASK, 4, "t1_mask");
        expect_at(5, S_STALL, 4, "t1_stall");
        expect_at(6, S_IRQ, 0, "t1_irq_pulse");
        expect_at(6, S_DL, 1, "t1_sticky");
        wait_done();

        // 3-cycle burst recovers, 4-cycle burst declares
        start();
        enable = 1'b1; threshold = 16'd4; axis_block_sigs = 4'b0001;
        expect_at(6, S_DL, 0, "t2_short_no_dl");
        expect_at(6, S_STALL, 3, "t2_short_stall");
        expect_at(6, S_MASK, 1, "t2_mask_kept");
        expect_at(12, S_DL, 0, "t2_no_dl_early");
        expect_at(13, S_DL, 1, "t2_deadlock");
        expect_at(13, S_IRQ, 1, "t2_irq");
        expect_at(13, S_IDX, 3, "t2_first_idx");
        expect_at(13, S_MASK, 8, "t2_mask");
        expect_at(14, S_STALL, 7, "t2_stall");
        goto_cycle(3);  axis_block_sigs = 4'b0000;
        goto_cycle(8);  axis_block_sigs = 4'b1000;
        goto_cycle(12); axis_block_sigs = 4'b0000;
        wait_done();

        // Clear in DEADLOCK with the block still held
        start();
        enable = 1'b1; threshold = 16'd4; axis_block_sigs = 4'b0010;
        expect_at(7, S_STALL, 6, "t3_stall_pre");
        expect_at(8, S_DL, 0, "t3_cleared");
        expect_at(8, S_STALL, 0, "t3_stall_cleared");
        expect_at(8, S_MASK, 0, "t3_mask_cleared");
        expect_at(11, S_DL, 0, "t3_no_dl_early");
        expect_at(12, S_DL, 1, "t3_redeclare");
        expect_at(12, S_IRQ, 1, "t3_irq");
        expect_at(12, S_STALL, 4, "t3_stall_restart");
        expect_at(12, S_IDX, 1, "t3_first_idx");
        goto_cycle(7); clear = 1'b1;
        goto_cycle(8); clear = 1'b0;
        wait_done();

        // Idle sub-instance never qualifies
        start();
        enable = 1'b1; threshold = 16'd4; inst_block_sigs = 1'b1; inst_idle_sigs = 1'b1;
        expect_at(2, S_BLK, 0, "t4_idle_blk");
        expect_at(8, S_DL, 0, "t4_idle_no_dl");
        expect_at(8, S_STALL, 0, "t4_idle_stall");
        wait_done();

        // Busy blocked sub-instance, threshold 1
        start();
        enable = 1'b1; threshold = 16'd1; inst_block_sigs = 1'b1; inst_idle_sigs = 1'b0;
        expect_at(1, S_BLK, 1, "t4_inst_blk");
        expect_at(1, S_DL, 0, "t4_inst_no_dl");
        expect_at(2, S_DL, 1, "t4_inst_dl");
        expect_at(2, S_IRQ, 1, "t4_inst_irq");
        expect_at(2, S_IDX, 0, "t4_inst_idx");
        expect_at(2, S_MASK, 0, "t4_inst_mask");
        wait_done();

        // Threshold 0 behaves as 1
        start();
        enable = 1'b1; threshold = 16'd0; axis_block_sigs = 4'b0001;
        expect_at(1, S_DL, 0, "t5_thr0_no_dl");
        expect_at(2, S_DL, 1, "t5_thr0_dl");
        expect_at(2, S_IRQ, 1, "t5_thr0_irq");
        expect_at(3, S_IRQ, 0, "t5_thr0_irq_off");
        wait_done();

        // enable drops mid-SUSPECT
        start();
        enable = 1'b1; threshold = 16'd4; axis_block_sigs = 4'b0100;
        expect_at(5, S_DL, 0, "t5_en_no_dl");
        expect_at(5, S_STALL, 3, "t5_en_stall");
        expect_at(10, S_DL, 0, "t5_en_no_dl_late");
        expect_at(10, S_STALL, 3, "t5_en_stall_frozen");
        expect_at(10, S_BLK, 1, "t5_en_block_now");
        goto_cycle(3); enable = 1'b0;
        wait_done();

        // 4-bit counters saturate; reset mid-SUSPECT
        start();
        enable = 1'b1; threshold = 16'd100; axis_block_sigs = 4'b0001;
        expect_at(15, S_DL_B, 0, "t6_b_no_dl");
        expect_at(16, S_DL_B, 1, "t6_b_dl");
        expect_at(16, S_STALL_B, 15, "t6_b_stall_max");
        expect_at(19, S_STALL_B, 15, "t6_b_stall_sat");
        expect_at(19, S_DL, 0, "t6_a_suspect");
        expect_at(20, S_STALL, 19, "t6_a_stall");
        expect_at(21, S_BLK, 0, "t6_rst_blk");
        expect_at(21, S_DL, 0, "t6_rst_dl");
        expect_at(21, S_STALL, 0, "t6_rst_stall");
        expect_at(21, S_MASK, 0, "t6_rst_mask");
        goto_cycle(20); reset = 1'b1;
        goto_cycle(21); reset = 1'b0;
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
